// File: rtl/noc_flit_pkg.sv
// Shared NoC flit definitions: type codes, packetizer states, HEAD body builder.
// Latency: none (declarations and a pure function only).
// Backpressure: not applicable.
package noc_flit_pkg;

  // Type identifier carried in the flit MSBs; DEFAULT is never put on the link.
  localparam int unsigned FLIT_DEFAULT = 0;
  localparam int unsigned FLIT_HEAD    = 1;
  localparam int unsigned FLIT_PAYLOAD = 2;
  localparam int unsigned FLIT_TAIL    = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEAD,
    S_BODY,
    S_TAIL
  } pkt_state_e;

  // HEAD body: dest sits directly under the type field, len in the LSBs,
  // everything between is zero. Computed wide so any width set fits; the
  // caller narrows the result to its body width.
  function automatic logic [63:0] head_body(
    input logic [31:0] dest,
    input logic [31:0] len,
    input int unsigned body_w,
    input int unsigned dest_w,
    input int unsigned len_w
  );
    logic [63:0] d;
    logic [63:0] l;
    d = {32'd0, dest} & ((64'd1 << dest_w) - 64'd1);
    l = {32'd0, len} & ((64'd1 << len_w) - 64'd1);
    return (d << (body_w - dest_w)) | l;
  endfunction

endpackage

// File: rtl/flit_encoder.sv
// Assembles {type, body}: HEAD takes dest/len, PAYLOAD/TAIL take the data word.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is loaded.
module flit_encoder
  import noc_flit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TYPE_WIDTH = 2,
  parameter int DEST_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic [TYPE_WIDTH-1:0]            ftype,
  input  logic [DEST_WIDTH-1:0]            dest,
  input  logic [LEN_WIDTH-1:0]             len,
  input  logic [DATA_WIDTH-TYPE_WIDTH-1:0] data,
  output logic [DATA_WIDTH-1:0]            flit
);

  localparam int BODY_WIDTH = DATA_WIDTH - TYPE_WIDTH;

  // Select the body by flit type and prepend the type code.
  always_comb begin
    if (ftype == TYPE_WIDTH'(FLIT_HEAD)) begin
      flit = {ftype, BODY_WIDTH'(head_body(32'(dest), 32'(len), BODY_WIDTH, DEST_WIDTH, LEN_WIDTH))};
    end else begin
      flit = {ftype, data};
    end
  end

endmodule

// File: rtl/flit_packetizer.sv
// Turns a descriptor plus payload words into HEAD, PAYLOAD*, TAIL flits.
// Latency: HEAD registered one cycle after descriptor accept; 1 flit/cycle after that.
// Backpressure: output register held while flit_ready=0; pld_ready only when it can be reloaded.
module flit_packetizer
  import noc_flit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TYPE_WIDTH = 2,
  parameter int DEST_WIDTH = 4,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             pkt_valid,
  output logic                             pkt_ready,
  input  logic [DEST_WIDTH-1:0]            pkt_dest,
  input  logic [LEN_WIDTH-1:0]             pkt_len,
  input  logic [DATA_WIDTH-TYPE_WIDTH-1:0] pld_data,
  input  logic                             pld_valid,
  output logic                             pld_ready,
  output logic [DATA_WIDTH-1:0]            flit_out,
  output logic                             flit_valid,
  input  logic                             flit_ready
);

  localparam int BODY_WIDTH = DATA_WIDTH - TYPE_WIDTH;

  pkt_state_e state_q, state_d;
  logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;   // payload words still to be consumed
  logic [DATA_WIDTH-1:0] flit_q;
  logic                  vld_q, vld_d;
  logic                  load;

  logic                  accept;
  logic                  load_ok;
  logic                  want_word;
  logic                  take_pkt;
  logic                  take_word;
  logic [TYPE_WIDTH-1:0] enc_type;
  logic [BODY_WIDTH-1:0] enc_data;
  logic [DATA_WIDTH-1:0] enc_flit;

  // HEAD is only ever built in the descriptor-accept cycle, so the encoder
  // reads dest/len straight off the descriptor port; the HEAD flit sitting in
  // the output register is what keeps them afterwards.
  flit_encoder #(
    .DATA_WIDTH (DATA_WIDTH),
    .TYPE_WIDTH (TYPE_WIDTH),
    .DEST_WIDTH (DEST_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_encoder (
    .ftype (enc_type),
    .dest  (pkt_dest),
    .len   (pkt_len),
    .data  (enc_data),
    .flit  (enc_flit)
  );

  // Next-state, handshakes and what (if anything) to load into the output register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    load     = 1'b0;
    enc_type = TYPE_WIDTH'(FLIT_DEFAULT);
    enc_data = '0;

    accept  = vld_q && flit_ready;
    load_ok = !vld_q || flit_ready;

    // The first word is pulled in the same cycle the HEAD is accepted, so the
    // HEAD is followed by payload without a bubble; while the HEAD is stalled
    // load_ok is low and payload is left alone.
    case (state_q)
      S_HEAD:  want_word = (cnt_q != '0);
      S_BODY:  want_word = 1'b1;
      S_TAIL:  want_word = (cnt_q == LEN_WIDTH'(1));
      default: want_word = 1'b0;
    endcase

    pkt_ready = rst && (state_q == S_IDLE);
    pld_ready = rst && want_word && load_ok;
    take_pkt  = pkt_valid && pkt_ready;
    take_word = pld_valid && pld_ready;

    if (take_pkt) begin
      enc_type = TYPE_WIDTH'(FLIT_HEAD);
      load     = 1'b1;
      vld_d    = 1'b1;
      cnt_d    = pkt_len;
      state_d  = S_HEAD;
    end else if (take_word) begin
      // The last remaining word becomes the TAIL; earlier ones are PAYLOAD.
      enc_type = (cnt_q == LEN_WIDTH'(1)) ? TYPE_WIDTH'(FLIT_TAIL) : TYPE_WIDTH'(FLIT_PAYLOAD);
      enc_data = pld_data;
      load     = 1'b1;
      vld_d    = 1'b1;
      cnt_d    = cnt_q - LEN_WIDTH'(1);
      state_d  = (cnt_q <= LEN_WIDTH'(2)) ? S_TAIL : S_BODY;
    end else if (accept) begin
      if (state_q == S_HEAD && cnt_q == '0) begin
        // Empty packet: a zero-body TAIL follows the HEAD directly.
        enc_type = TYPE_WIDTH'(FLIT_TAIL);
        load     = 1'b1;
        state_d  = S_TAIL;
      end else if (state_q == S_TAIL && cnt_q == '0) begin
        vld_d   = 1'b0;
        state_d = S_IDLE;
      end else begin
        // Payload starved: the register drains, no filler flit is made.
        vld_d = 1'b0;
        if (state_q == S_HEAD) begin
          state_d = (cnt_q == LEN_WIDTH'(1)) ? S_TAIL : S_BODY;
        end
      end
    end
  end

  // State, counter and output register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      flit_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      if (load) begin
        flit_q <= enc_flit;
      end
    end
  end

  assign flit_out   = flit_q;
  assign flit_valid = vld_q;

endmodule

// File: tb/tb_flit_packetizer.sv
// Bench for flit_packetizer: directed and randomized packets against a flit-list model.
// Latency: checks HEAD one cycle after accept and back-to-back flits when unstalled.
// Backpressure: random flit_ready stalls and payload gaps, with hold-stability checks.
module tb_flit_packetizer;

  logic        clk;
  logic        rst;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [3:0]  pkt_dest;
  logic [3:0]  pkt_len;
  logic [29:0] pld_data;
  logic        pld_valid;
  logic        pld_ready;
  logic [31:0] flit_out;
  logic        flit_valid;
  logic        flit_ready;

  int checks   = 0;
  int failures = 0;

  flit_packetizer dut (
    .clk        (clk),
    .rst        (rst),
    .pkt_valid  (pkt_valid),
    .pkt_ready  (pkt_ready),
    .pkt_dest   (pkt_dest),
    .pkt_len    (pkt_len),
    .pld_data   (pld_data),
    .pld_valid  (pld_valid),
    .pld_ready  (pld_ready),
    .flit_out   (flit_out),
    .flit_valid (flit_valid),
    .flit_ready (flit_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sends one packet and checks every flit on the link against a list built
  // from the packet definition. stall_pct>0 enables random flit_ready stall
  // runs of 1-5 cycles and random payload gaps; gap_mode inserts one 3-cycle
  // payload gap after the second word; check_rate verifies the packet takes
  // exactly one cycle per flit; abort_after>0 returns once that many flits
  // have been accepted (packet left unfinished).
  task automatic run_packet(input logic [3:0] dest, input logic [3:0] len,
                            input int stall_pct, input bit gap_mode,
                            input bit check_rate, input int abort_after);
    logic [29:0] words[$];
    logic [31:0] expq[$];
    logic [31:0] prev_flit;
    int          nflits, widx, nacc, last_cyc, gap_left, gap_pos, stall_left;
    bit          gap_done, prev_stall;

    widx = 0; nacc = 0; last_cyc = 0; gap_left = 0; gap_pos = -1;
    stall_left = 0; gap_done = 1'b0; prev_stall = 1'b0; prev_flit = '0;

    for (int i = 0; i < int'(len); i++) words.push_back(30'($urandom));
    expq.push_back((32'd1 << 30) | (32'(dest) << 26) | 32'(len));
    if (len == 4'd0) begin
      expq.push_back(32'd3 << 30);
    end else begin
      for (int i = 0; i < int'(len); i++)
        expq.push_back(((i == int'(len) - 1) ? (32'd3 << 30) : (32'd2 << 30)) | 32'(words[i]));
    end
    nflits = expq.size();

    // Descriptor: the packetizer must be idle and take it at the next edge.
    @(negedge clk);
    pkt_valid = 1'b1; pkt_dest = dest; pkt_len = len;
    flit_ready = 1'b0; pld_valid = 1'b0; pld_data = 30'($urandom);
    #1;
    check("pkt_ready_idle", 32'(pkt_ready), 32'd1);

    for (int cyc = 1; cyc <= 400 && expq.size() > 0; cyc++) begin
      @(negedge clk);
      // A conflicting descriptor stays on the port; it must be ignored.
      pkt_valid = 1'b1; pkt_dest = ~dest; pkt_len = ~len;

      if (stall_pct > 0 && !gap_mode) begin
        if (stall_left == 0 && int'($urandom_range(99)) < stall_pct)
          stall_left = int'($urandom_range(5, 1));
        flit_ready = (stall_left == 0);
        if (stall_left > 0) stall_left--;
      end else begin
        flit_ready = 1'b1;
      end

      if (gap_mode && !gap_done && widx == 2) begin
        gap_left = 3; gap_done = 1'b1;
      end
      gap_pos = -1;
      if (gap_left > 0) begin
        gap_pos = 3 - gap_left;
        gap_left--;
        pld_valid = 1'b0;
      end else if (stall_pct > 0) begin
        pld_valid = ($urandom_range(3) != 0);
      end else begin
        pld_valid = 1'b1;
      end
      pld_data = (widx < int'(len)) ? words[widx] : 30'($urandom);

      #1;
      if (prev_stall) begin
        check("hold_valid", 32'(flit_valid), 32'd1);
        check("hold_data", flit_out, prev_flit);
      end
      if (gap_pos >= 1) check("gap_valid", 32'(flit_valid), 32'd0);
      check("pkt_ready_busy", 32'(pkt_ready), 32'd0);
      if (flit_valid && flit_ready) begin
        check("flit", flit_out, expq.pop_front());
        nacc++;
        last_cyc = cyc;
      end
      if (pld_valid && pld_ready) widx++;
      prev_stall = flit_valid && !flit_ready;
      prev_flit  = flit_out;
      if (abort_after > 0 && nacc == abort_after) break;
    end

    if (abort_after == 0) begin
      check("flits_left", 32'(expq.size()), 32'd0);
      check("words_used", 32'(widx), 32'(len));
      if (check_rate) check("tail_cycle", 32'(last_cyc), 32'(nflits));
      @(negedge clk);
      pkt_valid = 1'b0; flit_ready = 1'b0; pld_valid = 1'b0;
      #1;
      check("pkt_ready_after_tail", 32'(pkt_ready), 32'd1);
      check("idle_valid", 32'(flit_valid), 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0; pkt_valid = 1'b0; pkt_dest = '0; pkt_len = '0;
    pld_data = '0; pld_valid = 1'b0; flit_ready = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk);
    pkt_valid = 1'b1; pld_valid = 1'b1; flit_ready = 1'b1;
    #1;
    check("rst_flit_valid", 32'(flit_valid), 32'd0);
    check("rst_flit_out", flit_out, 32'd0);
    check("rst_pkt_ready", 32'(pkt_ready), 32'd0);
    check("rst_pld_ready", 32'(pld_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1; pkt_valid = 1'b0; pld_valid = 1'b0; flit_ready = 1'b0;
    #1;
    check("post_rst_pkt_ready", 32'(pkt_ready), 32'd1);

    // Directed packets.
    run_packet(4'd5, 4'd3, 0, 1'b0, 1'b1, 0);
    run_packet(4'd2, 4'd0, 0, 1'b0, 1'b1, 0);
    run_packet(4'd9, 4'd1, 0, 1'b0, 1'b1, 0);
    run_packet(4'd14, 4'd2, 0, 1'b0, 1'b1, 0);
    run_packet(4'd15, 4'd15, 0, 1'b0, 1'b1, 0);
    for (int k = 0; k < 3; k++) run_packet(4'($urandom), 4'd4, 40, 1'b0, 1'b0, 0);
    run_packet(4'd3, 4'd4, 0, 1'b1, 1'b0, 0);

    // Reset in the middle of a packet, then a clean packet.
    run_packet(4'd7, 4'd5, 0, 1'b0, 1'b0, 2);
    @(negedge clk);
    rst = 1'b0; pkt_valid = 1'b0; flit_ready = 1'b1; pld_valid = 1'b1;
    @(negedge clk);
    #1;
    check("midrst_flit_valid", 32'(flit_valid), 32'd0);
    check("midrst_flit_out", flit_out, 32'd0);
    check("midrst_pkt_ready", 32'(pkt_ready), 32'd0);
    check("midrst_pld_ready", 32'(pld_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1; flit_ready = 1'b0; pld_valid = 1'b0;
    #1;
    check("midrst_idle", 32'(pkt_ready), 32'd1);
    run_packet(4'd6, 4'd2, 0, 1'b0, 1'b1, 0);

    // Randomized packets with stalls and payload gaps.
    for (int k = 0; k < 8; k++)
      run_packet(4'($urandom), 4'($urandom_range(15)), 30, 1'b0, 1'b0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
